// File: rtl/nibble_dispenser.sv
// nibble_dispenser: loads an 8-bit total and streams it out as chunks of at
// most MAX_STEP over a valid/ready handshake. Every output is a register.
module nibble_dispenser #(
  parameter int unsigned MAX_STEP = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] total,
  output logic [3:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] remaining,
  output logic [7:0] chunk_count
);

  if (MAX_STEP < 1 || MAX_STEP > 15) begin : g_bad_max_step
    $error("nibble_dispenser: MAX_STEP must be in 1..15");
  end

  localparam logic [7:0] MAX_STEP8 = 8'(MAX_STEP);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] data_nxt;
  logic       valid_nxt;
  logic [7:0] rem_nxt;
  logic [7:0] cnt_nxt;
  logic [7:0] left;

  function automatic logic [3:0] clip(input logic [7:0] v);
    if (v > MAX_STEP8) return MAX_STEP8[3:0];
    return v[3:0];
  endfunction

  // Next-state and next-output computation; everything holds by default.
  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    valid_nxt = data_valid;
    rem_nxt   = remaining;
    cnt_nxt   = chunk_count;
    left      = remaining - {4'b0000, data};
    unique case (state)
      IDLE: begin
        if (load) begin
          rem_nxt = total;
          cnt_nxt = '0;
          if (total != '0) begin
            state_nxt = EMIT;
            valid_nxt = 1'b1;
            data_nxt  = clip(total);
          end else begin
            state_nxt = DONE;
          end
        end
      end
      EMIT: begin
        if (data_valid && data_ready) begin
          rem_nxt = left;
          cnt_nxt = (chunk_count == '1) ? chunk_count : chunk_count + 8'd1;
          if (left == '0) begin
            valid_nxt = 1'b0;
            data_nxt  = '0;
            state_nxt = DONE;
          end else begin
            data_nxt = clip(left);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are decoded from the next state
  // so that they come straight out of flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      data        <= '0;
      data_valid  <= 1'b0;
      remaining   <= '0;
      chunk_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      data        <= data_nxt;
      data_valid  <= valid_nxt;
      remaining   <= rem_nxt;
      chunk_count <= cnt_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_nibble_dispenser.sv
// Directed self-checking bench for nibble_dispenser (MAX_STEP=15 and 4).
module tb_nibble_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       load = 1'b0;
  logic [7:0] total = '0;
  logic       data_ready = 1'b0;
  logic [3:0] data;
  logic       data_valid, busy, done;
  logic [7:0] remaining, chunk_count;

  logic       load4 = 1'b0;
  logic [7:0] total4 = '0;
  logic       ready4 = 1'b0;
  logic [3:0] data4;
  logic       valid4, busy4, done4;
  logic [7:0] rem4, cnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nibble_dispenser #(.MAX_STEP(15)) u_dut (
    .clk(clk), .reset(reset), .load(load), .total(total),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .remaining(remaining), .chunk_count(chunk_count)
  );

  nibble_dispenser #(.MAX_STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .load(load4), .total(total4),
    .data(data4), .data_valid(valid4), .data_ready(ready4),
    .busy(busy4), .done(done4), .remaining(rem4), .chunk_count(cnt4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, chunks, bad, seen_done, pulses;

    // Reset values
    #2;
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_cnt", chunk_count, 0);
    chk("rst4_valid", valid4, 0);
    tick();
    reset = 1'b1;
    tick();

    // 1: total=40, ready high -> 15,15,10
    data_ready = 1'b1; load = 1'b1; total = 8'd40;
    tick();
    load = 1'b0; total = 8'd77;
    chk("t1_d0", data, 15);  chk("t1_v0", data_valid, 1);
    chk("t1_busy", busy, 1); chk("t1_rem0", remaining, 40);
    chk("t1_cnt0", chunk_count, 0);
    tick();
    chk("t1_d1", data, 15);  chk("t1_rem1", remaining, 25);
    tick();
    chk("t1_d2", data, 10);  chk("t1_rem2", remaining, 10);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1); chk("t1_v3", data_valid, 0);
    chk("t1_data3", data, 0);
    chk("t1_cnt", chunk_count, 3); chk("t1_rem", remaining, 0);
    tick();
    chk("t1_done_clr", done, 0); chk("t1_busy_clr", busy, 0);

    // 2: total=0 -> immediate done, busy one cycle
    load = 1'b1; total = 8'd0;
    tick();
    load = 1'b0;
    chk("t2_done", done, 1); chk("t2_valid", data_valid, 0);
    chk("t2_busy", busy, 1); chk("t2_cnt", chunk_count, 0);
    tick();
    chk("t2_done_clr", done, 0); chk("t2_busy_clr", busy, 0);

    // 3: total=255 -> 17 chunks of 15, accumulator reaches 255
    load = 1'b1; total = 8'd255;
    tick();
    load = 1'b0;
    acc = 0; chunks = 0; bad = 0; seen_done = 0;
    for (int i = 0; i < 40 && seen_done == 0; i++) begin
      if (data_valid && data_ready) begin
        acc += data;
        chunks++;
        if (data != 4'd15) bad++;
      end
      tick();
      if (done) seen_done = 1;
    end
    chk("t3_done_seen", seen_done, 1);
    chk("t3_chunks", chunks, 17);
    chk("t3_not15", bad, 0);
    chk("t3_acc", acc, 255);
    chk("t3_cnt", chunk_count, 17);
    chk("t3_rem", remaining, 0);
    tick();

    // 4: backpressure on total=20
    data_ready = 1'b0; load = 1'b1; total = 8'd20;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_d", data, 15); chk("t4_hold_v", data_valid, 1);
      chk("t4_hold_rem", remaining, 20);
      tick();
    end
    chk("t4_hold_d", data, 15); chk("t4_hold_cnt", chunk_count, 0);
    data_ready = 1'b1;
    tick();
    chk("t4_d_last", data, 5); chk("t4_rem", remaining, 5);
    chk("t4_cnt1", chunk_count, 1);
    tick();
    chk("t4_done", done, 1); chk("t4_cnt", chunk_count, 2);
    chk("t4_rem0", remaining, 0);
    tick();

    // 5: reset mid-transfer, then total=7
    load = 1'b1; total = 8'd100;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("t5_cnt2", chunk_count, 2); chk("t5_rem70", remaining, 70);
    reset = 1'b0;
    #1;
    chk("t5_r_valid", data_valid, 0); chk("t5_r_data", data, 0);
    chk("t5_r_busy", busy, 0);        chk("t5_r_rem", remaining, 0);
    chk("t5_r_cnt", chunk_count, 0);  chk("t5_r_done", done, 0);
    tick();
    chk("t5_r_done2", done, 0);
    reset = 1'b1;
    tick();
    chk("t5_idle_done", done, 0); chk("t5_idle_valid", data_valid, 0);
    load = 1'b1; total = 8'd7;
    tick();
    load = 1'b0;
    chk("t5_d7", data, 7); chk("t5_v7", data_valid, 1);
    tick();
    chk("t5_done", done, 1); chk("t5_cnt", chunk_count, 1);
    chk("t5_rem", remaining, 0);
    tick();

    // 6: MAX_STEP=4, total=10, load re-asserted with 99 during EMIT/DONE
    ready4 = 1'b1; load4 = 1'b1; total4 = 8'd10;
    tick();
    total4 = 8'd99;
    pulses = 0;
    chk("t6_d0", data4, 4); chk("t6_rem0", rem4, 10);
    tick();
    chk("t6_d1", data4, 4); chk("t6_rem1", rem4, 6);
    tick();
    chk("t6_d2", data4, 2); chk("t6_rem2", rem4, 2);
    tick();
    if (done4) pulses++;
    chk("t6_done", done4, 1); chk("t6_cnt", cnt4, 3);
    chk("t6_rem", rem4, 0);
    load4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done4) pulses++;
    end
    chk("t6_pulses", pulses, 1);
    chk("t6_busy", busy4, 0); chk("t6_valid", valid4, 0);
    chk("t6_cnt_hold", cnt4, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_dispenser.md
Name: nibble_dispenser

Overview:
Inverse of the team's nibble accumulator. Loads an 8-bit total and emits it as a stream of 4-bit chunks over a valid/ready handshake. Summing every accepted chunk in an accumulator reproduces the loaded total exactly. It sits upstream of an accumulator and drives its data input, one accepted chunk per clock.

Parameters:
MAX_STEP, 15, largest chunk value emitted; legal range 1..15; elaboration must fail outside this range.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
load  input  1  start request; sampled only in IDLE
total  input  8  value to dispense; captured on accepted load
data  output  4  current chunk value
data_valid  output  1  data holds a chunk awaiting acceptance
data_ready  input  1  downstream accepts chunk when high together with data_valid
busy  output  1  high in EMIT and DONE states
done  output  1  one-cycle pulse after the final chunk is accepted, or after a zero-total load
remaining  output  8  amount not yet accepted
chunk_count  output  8  chunks accepted since last load

Behaviour:
- Reset (reset==0, asynchronous, any state): state=IDLE, data=0, data_valid=0, busy=0, done=0, remaining=0, chunk_count=0. This applies mid-transfer: the partial transfer is abandoned with no done pulse. Operation resumes on the first rising edge with reset==1.
- All outputs are registered. No combinational path from any input to any output.
- FSM states are IDLE, EMIT and DONE.
- IDLE with load==1 at a clock edge:
  - remaining<=total and chunk_count<=0.
  - If total!=0: go to EMIT, data_valid<=1, data<=min(total,MAX_STEP).
  - If total==0: go to DONE, data_valid stays 0.
- IDLE with load==0: hold all registers.
- Latency: load accepted at edge k gives data_valid=1 after edge k, so the first chunk is visible in the next cycle.
- EMIT, handshake:
  - A transfer occurs at an edge where data_valid && data_ready.
  - Without a transfer, data, data_valid, remaining and chunk_count hold stable.
  - data_valid never drops before acceptance.
- EMIT, on a transfer:
  - remaining<=remaining-data.
  - chunk_count<=chunk_count+1, saturating at 255; saturation is unreachable with legal MAX_STEP but is required anyway.
  - If remaining-data==0: data_valid<=0, data<=0, go to DONE.
  - Otherwise: data<=min(remaining-data,MAX_STEP), data_valid stays 1, stay in EMIT.
  - Back-to-back transfers run every cycle while data_ready stays high.
- Arithmetic: remaining never underflows, because data<=remaining by construction. Every chunk satisfies 1<=data<=MAX_STEP. All chunks equal MAX_STEP except possibly the last, which is the remainder.
- DONE: done=1 for exactly one cycle, then go to IDLE. done is 0 in every other state.
- busy=1 in EMIT and DONE; busy=0 in IDLE.
- load is ignored in EMIT and DONE, including load asserted in the DONE cycle. total is only sampled on an accepted load.
- data_ready is ignored while data_valid==0.
- A load accepted in IDLE in the cycle immediately after DONE is legal, so a new transfer may start 1 cycle after done.
- Invariant at every edge outside reset: remaining + sum(accepted chunks since load) == captured total.

Test Plan:
1. MAX_STEP=15, total=40, data_ready tied 1 -> data sequence 15,15,10 on three consecutive cycles; done pulses the cycle after the 10 is accepted; chunk_count=3; remaining=0.
2. total=0 -> no data_valid assertion; done pulses one cycle after the load edge; chunk_count=0; busy high for exactly 1 cycle.
3. total=255, MAX_STEP=15, ready=1 -> 17 chunks of 15; chunk_count=17. Drive the output into the team accumulator (reset to 0) and require acc_reg=255 at done.
4. Backpressure: total=20, data_ready low for 3 cycles after first valid, then high -> data=15 held stable for 4 cycles, then 5, then done; remaining=20 throughout the stall.
5. Reset mid-transfer: total=100, assert reset after 2 accepted chunks -> all outputs 0 immediately, no done pulse. A new load of total=7 then gives a single chunk 7 and done.
6. MAX_STEP=4 build, total=10; load re-asserted with total=99 during EMIT -> chunks 4,4,2 only; the 99 is ignored; exactly one done pulse.
